// File: rtl/phi_pingpong_store.sv
// Ping-pong phi store for the Jacobi solver: two banks trade prev/next roles every
// iteration, with NRD two-cycle read ports on the prev bank and a run sequencer.
module phi_pingpong_store #(
    parameter int PHIWIDTH       = 16,
    parameter int GRID_ADDRWIDTH = 4,
    parameter int DWIDTH         = PHIWIDTH,
    parameter int AWIDTH         = GRID_ADDRWIDTH,
    parameter int NRD            = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [15:0]             max_iter,
    input  logic                    wr_valid,
    input  logic [AWIDTH-1:0]       wr_addr,
    input  logic [DWIDTH-1:0]       wr_data,
    input  logic [NRD*AWIDTH-1:0]   rd_addr,
    output logic [NRD*DWIDTH-1:0]   rd_data,
    output logic                    ready,
    output logic                    iter_done,
    output logic                    run_done,
    output logic [15:0]             iter_count,
    output logic                    wr_err
);
    localparam int DEPTH = 2 ** AWIDTH;
    localparam logic [AWIDTH:0]   WR_FULL  = (AWIDTH+1)'(DEPTH);
    localparam logic [AWIDTH-1:0] CLR_LAST = AWIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {CLEAR, IDLE, RUN, SWAP} state_t;
    state_t state, state_next;

    logic [DWIDTH-1:0] bank_a [DEPTH];
    logic [DWIDTH-1:0] bank_b [DEPTH];

    logic              sel;
    logic [AWIDTH-1:0] clr_cnt;
    logic [AWIDTH:0]   wr_cnt;
    logic [AWIDTH:0]   wr_cnt_inc;
    logic [15:0]       max_iter_q;
    logic [15:0]       iter_count_q;
    logic [15:0]       iter_inc;
    logic              wr_err_q;
    logic              run_wr;
    logic              wr_last;
    logic              iter_last;

    logic [AWIDTH-1:0] rd_addr_q [NRD];
    logic [DWIDTH-1:0] rd_data_q [NRD];
    logic              rd_sel_q;
    logic              rd_clr_q;

    assign run_wr     = (state == RUN) && wr_valid;
    assign wr_cnt_inc = wr_cnt + 1'b1;
    assign wr_last    = run_wr && (wr_cnt_inc == WR_FULL);
    assign iter_inc   = iter_count_q + 16'd1;
    assign iter_last  = (iter_inc == max_iter_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= CLEAR;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            CLEAR: if (clr_cnt == CLR_LAST) state_next = IDLE;
            IDLE:  if (start)               state_next = RUN;
            RUN:   if (wr_last)             state_next = SWAP;
            SWAP:  state_next = iter_last ? IDLE : RUN;
            default: state_next = CLEAR;
        endcase
    end

    always_comb begin
        ready     = 1'b0;
        iter_done = 1'b0;
        run_done  = 1'b0;
        case (state)
            IDLE: ready = 1'b1;
            SWAP: begin
                iter_done = 1'b1;
                run_done  = iter_last;
            end
            default: ;
        endcase
    end

    // Run bookkeeping; sel deliberately survives runs so the next run starts from the last result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel          <= 1'b0;
            clr_cnt      <= '0;
            wr_cnt       <= '0;
            max_iter_q   <= 16'd1;
            iter_count_q <= 16'd0;
            wr_err_q     <= 1'b0;
        end else begin
            if (wr_valid && (state != RUN)) wr_err_q <= 1'b1;
            case (state)
                CLEAR: clr_cnt <= clr_cnt + 1'b1;
                IDLE: begin
                    if (start) begin
                        max_iter_q   <= (max_iter == 16'd0) ? 16'd1 : max_iter;
                        iter_count_q <= 16'd0;
                        wr_cnt       <= '0;
                    end
                end
                RUN: if (wr_valid) wr_cnt <= wr_cnt_inc;
                SWAP: begin
                    sel          <= ~sel;
                    wr_cnt       <= '0;
                    iter_count_q <= iter_inc;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            bank_a[clr_cnt] <= '0;
            bank_b[clr_cnt] <= '0;
        end else if (run_wr) begin
            if (sel) bank_a[wr_addr] <= wr_data;
            else     bank_b[wr_addr] <= wr_data;
        end
    end

    // Bank choice and the clear flag travel with the address so data matches its sample cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_sel_q <= 1'b0;
            rd_clr_q <= 1'b1;
            for (int i = 0; i < NRD; i++) begin
                rd_addr_q[i] <= '0;
                rd_data_q[i] <= '0;
            end
        end else begin
            rd_sel_q <= sel;
            rd_clr_q <= (state == CLEAR);
            for (int i = 0; i < NRD; i++) begin
                rd_addr_q[i] <= rd_addr[i*AWIDTH +: AWIDTH];
                if (rd_clr_q)      rd_data_q[i] <= '0;
                else if (rd_sel_q) rd_data_q[i] <= bank_b[rd_addr_q[i]];
                else               rd_data_q[i] <= bank_a[rd_addr_q[i]];
            end
        end
    end

    for (genvar g = 0; g < NRD; g++) begin : g_rd_pack
        assign rd_data[g*DWIDTH +: DWIDTH] = rd_data_q[g];
    end

    assign iter_count = iter_count_q;
    assign wr_err     = wr_err_q;

endmodule

// File: tb/tb_phi_pingpong_store.sv
// Directed bench for phi_pingpong_store (AWIDTH=4, DWIDTH=16, NRD=8) with
// hand-computed expectations for clear, runs, swaps, error flag and reset.
module tb_phi_pingpong_store;
    localparam int DW  = 16;
    localparam int AW  = 4;
    localparam int NRD = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [15:0]       max_iter;
    logic              wr_valid;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*DW-1:0] rd_data;
    logic              ready;
    logic              iter_done;
    logic              run_done;
    logic [15:0]       iter_count;
    logic              wr_err;

    int checks = 0;
    int errors = 0;

    phi_pingpong_store #(.PHIWIDTH(DW), .GRID_ADDRWIDTH(AW), .DWIDTH(DW), .AWIDTH(AW), .NRD(NRD)) dut (
        .clk(clk), .rst(rst), .start(start), .max_iter(max_iter),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .ready(ready),
        .iter_done(iter_done), .run_done(run_done), .iter_count(iter_count), .wr_err(wr_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input int a, input int d);
        wr_valid = 1'b1;
        wr_addr  = AW'(a);
        wr_data  = DW'(d);
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic set_rd(input int base);
        for (int p = 0; p < NRD; p++) rd_addr[p*AW +: AW] = AW'((base + p) % 16);
    endtask

    function automatic logic [DW-1:0] port_data(input int p);
        return rd_data[p*DW +: DW];
    endfunction

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic begin_run(input int iters);
        max_iter = 16'(iters);
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        tick(); tick(); tick();
        checks++; if (ready !== 1'b0)      begin errors++; $display("[TB] FAIL reset_ready got %0b exp 0", ready); end
        checks++; if (iter_done !== 1'b0)  begin errors++; $display("[TB] FAIL reset_iter_done got %0b exp 0", iter_done); end
        checks++; if (run_done !== 1'b0)   begin errors++; $display("[TB] FAIL reset_run_done got %0b exp 0", run_done); end
        checks++; if (iter_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_iter_count got %0d exp 0", iter_count); end
        checks++; if (wr_err !== 1'b0)     begin errors++; $display("[TB] FAIL reset_wr_err got %0b exp 0", wr_err); end
        checks++; if (rd_data !== '0)      begin errors++; $display("[TB] FAIL reset_rd_data got %h exp 0", rd_data); end
        rst = 1'b0;
        wait_ready(n);
        checks++; if (n !== 16) begin errors++; $display("[TB] FAIL clear_cycles got %0d exp 16", n); end
        set_rd(0);
        tick(); tick();
        for (int p = 0; p < NRD; p++) begin
            checks++;
            if (port_data(p) !== DW'(0)) begin errors++; $display("[TB] FAIL idle_read_zero port %0d got %0d exp 0", p, port_data(p)); end
        end
    endtask

    task automatic test_single_run();
        begin_run(1);
        for (int k = 0; k < 16; k++) begin
            write_word(k, k + 1);
            if (k < 15) begin
                checks++;
                if (iter_done !== 1'b0) begin errors++; $display("[TB] FAIL early_iter_done write %0d got %0b exp 0", k, iter_done); end
            end
        end
        checks++; if (iter_done !== 1'b1) begin errors++; $display("[TB] FAIL single_iter_done got %0b exp 1", iter_done); end
        checks++; if (run_done !== 1'b1)  begin errors++; $display("[TB] FAIL single_run_done got %0b exp 1", run_done); end
        tick();
        checks++; if (ready !== 1'b1)       begin errors++; $display("[TB] FAIL single_ready got %0b exp 1", ready); end
        checks++; if (iter_count !== 16'd1) begin errors++; $display("[TB] FAIL single_iter_count got %0d exp 1", iter_count); end
        checks++; if (iter_done !== 1'b0)   begin errors++; $display("[TB] FAIL single_pulse_len got %0b exp 0", iter_done); end
        set_rd(5);
        tick(); tick();
        for (int p = 0; p < NRD; p++) begin
            checks++;
            if (port_data(p) !== DW'(((5 + p) % 16) + 1))
                begin errors++; $display("[TB] FAIL single_read port %0d got %0d exp %0d", p, port_data(p), ((5 + p) % 16) + 1); end
        end
    endtask

    task automatic test_multi_iter();
        begin_run(3);
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                set_rd(0);
                tick(); tick();
                for (int p = 0; p < NRD; p++) begin
                    checks++;
                    if (port_data(p) !== DW'(p)) begin errors++; $display("[TB] FAIL iter1_prev_read port %0d got %0d exp %0d", p, port_data(p), p); end
                end
            end
            for (int a = 0; a < 16; a++) write_word(a, 100 * i + a);
            checks++; if (iter_done !== 1'b1) begin errors++; $display("[TB] FAIL multi_iter_done iter %0d got %0b exp 1", i, iter_done); end
            checks++; if (run_done !== (i == 2)) begin errors++; $display("[TB] FAIL multi_run_done iter %0d got %0b exp %0b", i, run_done, (i == 2)); end
            tick();
            checks++; if (iter_count !== 16'(i + 1)) begin errors++; $display("[TB] FAIL multi_iter_count iter %0d got %0d exp %0d", i, iter_count, i + 1); end
        end
        checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL multi_ready got %0b exp 1", ready); end
        tick(); tick();
        checks++; if (iter_count !== 16'd3) begin errors++; $display("[TB] FAIL multi_count_hold got %0d exp 3", iter_count); end
    endtask

    task automatic test_wr_err_idle();
        checks++; if (wr_err !== 1'b0) begin errors++; $display("[TB] FAIL wr_err_before got %0b exp 0", wr_err); end
        write_word(3, 7);
        checks++; if (wr_err !== 1'b1) begin errors++; $display("[TB] FAIL wr_err_set got %0b exp 1", wr_err); end
        set_rd(3);
        tick(); tick();
        checks++; if (port_data(0) !== DW'(203)) begin errors++; $display("[TB] FAIL idle_write_ignored got %0d exp 203", port_data(0)); end
        checks++; if (port_data(1) !== DW'(204)) begin errors++; $display("[TB] FAIL idle_neighbour got %0d exp 204", port_data(1)); end
        tick(); tick(); tick();
        checks++; if (wr_err !== 1'b1) begin errors++; $display("[TB] FAIL wr_err_sticky got %0b exp 1", wr_err); end
        checks++; if (ready !== 1'b1)  begin errors++; $display("[TB] FAIL wr_err_state got ready %0b exp 1", ready); end
    endtask

    task automatic test_reset_mid_run();
        int n;
        begin_run(1);
        for (int k = 0; k < 8; k++) write_word(k, 9);
        #2 rst = 1'b1;
        #1;
        checks++; if (ready !== 1'b0)       begin errors++; $display("[TB] FAIL async_ready got %0b exp 0", ready); end
        checks++; if (iter_done !== 1'b0)   begin errors++; $display("[TB] FAIL async_iter_done got %0b exp 0", iter_done); end
        checks++; if (run_done !== 1'b0)    begin errors++; $display("[TB] FAIL async_run_done got %0b exp 0", run_done); end
        checks++; if (iter_count !== 16'd0) begin errors++; $display("[TB] FAIL async_iter_count got %0d exp 0", iter_count); end
        checks++; if (wr_err !== 1'b0)      begin errors++; $display("[TB] FAIL async_wr_err got %0b exp 0", wr_err); end
        checks++; if (rd_data !== '0)       begin errors++; $display("[TB] FAIL async_rd_data got %h exp 0", rd_data); end
        tick(); tick();
        rst = 1'b0;
        wait_ready(n);
        checks++; if (n !== 16) begin errors++; $display("[TB] FAIL reclear_cycles got %0d exp 16", n); end
        set_rd(3);
        tick(); tick();
        for (int p = 0; p < NRD; p++) begin
            checks++;
            if (port_data(p) !== DW'(0)) begin errors++; $display("[TB] FAIL reclear_read port %0d got %0d exp 0", p, port_data(p)); end
        end
    endtask

    task automatic test_same_addr();
        begin_run(1);
        write_word(0, 50);
        write_word(1, 51);
        set_rd(2);
        write_word(2, 52);
        write_word(3, 53);
        checks++; if (port_data(0) !== DW'(0)) begin errors++; $display("[TB] FAIL same_cycle_read got %0d exp 0", port_data(0)); end
        for (int k = 4; k < 15; k++) write_word(k, 50 + k);
        checks++; if (port_data(0) !== DW'(0)) begin errors++; $display("[TB] FAIL next_bank_hidden got %0d exp 0", port_data(0)); end
        write_word(15, 65);
        checks++; if (iter_done !== 1'b1) begin errors++; $display("[TB] FAIL same_iter_done got %0b exp 1", iter_done); end
        checks++; if (run_done !== 1'b1)  begin errors++; $display("[TB] FAIL same_run_done got %0b exp 1", run_done); end
        tick();
        tick();
        checks++; if (port_data(0) !== DW'(0))  begin errors++; $display("[TB] FAIL sel_at_sample got %0d exp 0", port_data(0)); end
        tick();
        checks++; if (port_data(0) !== DW'(52)) begin errors++; $display("[TB] FAIL after_swap_addr2 got %0d exp 52", port_data(0)); end
        checks++; if (port_data(1) !== DW'(53)) begin errors++; $display("[TB] FAIL after_swap_addr3 got %0d exp 53", port_data(1)); end
    endtask

    task automatic test_back_to_back();
        begin_run(0);
        for (int k = 1; k <= 16; k++) begin
            if (k == 5) begin
                start    = 1'b1;
                max_iter = 16'd5;
            end
            write_word(7, k);
            start = 1'b0;
            if (k < 16) begin
                checks++;
                if (iter_done !== 1'b0) begin errors++; $display("[TB] FAIL dup_early_iter_done write %0d got %0b exp 0", k, iter_done); end
            end
        end
        checks++; if (iter_done !== 1'b1) begin errors++; $display("[TB] FAIL dup_iter_done got %0b exp 1", iter_done); end
        checks++; if (run_done !== 1'b1)  begin errors++; $display("[TB] FAIL zero_iter_run_done got %0b exp 1", run_done); end
        tick();
        checks++; if (ready !== 1'b1)       begin errors++; $display("[TB] FAIL dup_ready got %0b exp 1", ready); end
        checks++; if (iter_count !== 16'd1) begin errors++; $display("[TB] FAIL dup_iter_count got %0d exp 1", iter_count); end
        set_rd(7);
        tick(); tick();
        checks++; if (port_data(0) !== DW'(16)) begin errors++; $display("[TB] FAIL dup_last_wins got %0d exp 16", port_data(0)); end
        checks++; if (port_data(1) !== DW'(0))  begin errors++; $display("[TB] FAIL dup_other_addr got %0d exp 0", port_data(1)); end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        max_iter = 16'd0;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        rd_addr  = '0;
        test_reset();
        test_single_run();
        test_multi_iter();
        test_wr_err_idle();
        test_reset_mid_run();
        test_same_addr();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout got running exp finished");
        $fatal(1, "[TB] watchdog");
    end

endmodule
